instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle controller that sequences the 16-bit instruction ALU datapath. It fetches instructions from a synchronous instruction ROM and decodes the opcode and immediate flag. It drives the register-bank read and write strobes and addresses, and captures the ALU result for write-back. It replaces manual key-driven execution with a PC-driven fetch/decode/read/execute/write loop, and supports free-run and single-step modes.

## Interface
Parameters:
- PC_W, 8, width of program counter / instruction ROM address
- HALT_OP, 4'b1111, opcode that stops the sequencer

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  level; high = free-run instructions back to back
- step  in  1  one-cycle pulse; executes exactly one instruction when run low
- imem_addr  out  PC_W  instruction ROM address
- imem_rdata  in  16  instruction word, valid 1 cycle after imem_addr
- rf_rd  out  1  register-bank read strobe
- rf_rd_addr_a  out  4  source A address (ir[7:4]; don't-care when immediate)
- rf_rd_addr_b  out  4  source B address (ir[3:0])
- rf_wr  out  1  register-bank write strobe, one cycle
- rf_wr_addr  out  4  destination address (ir[11:8])
- rf_wr_data  out  16  captured result
- alu_op  out  4  opcode ir[15:12]
- alu_imm  out  4  immediate ir[7:4]
- alu_imm_sel  out  1  1 for opcodes 0011, 0110–1010
- alu_result  in  16  combinational ALU output
- pc  out  PC_W  current program counter
- busy  out  1  high in any state other than IDLE/HALTED
- halted  out  1  high in HALTED
- instr_count  out  16  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, READ, EXEC, WRITE, HALTED.
- IDLE: if run → FETCH. Else if step → FETCH with step_mode set. Else stay.
- FETCH: imem_addr = pc. Next → DECODE.
- DECODE: ir ← imem_rdata. alu_imm_sel decoded.
  - Opcode == HALT_OP → HALTED, with no write and no PC change.
  - Otherwise → READ.
- READ: rf_rd=1 with both read addresses driven from ir. Next → EXEC.
- EXEC: alu_op/alu_imm/alu_imm_sel held from ir; rf_wr_data ← alu_result at end of cycle. Next → WRITE.
- WRITE:
  - Write strobe: rf_wr=1 and rf_wr_addr=ir[11:8] for defined opcodes (0000–1010). Undefined opcodes 1011–1110 are NOPs: rf_wr stays 0.
  - Counters: pc ← pc+1, wrapping from 2^PC_W−1 to 0. instr_count +1, saturating at 16'hFFFF.
  - Next state: → FETCH if run && !step_mode, else → IDLE; step_mode cleared.
- HALTED: outputs static. Left only via rst_n.
- Every instruction in flight always completes:
  - run falling mid-instruction: the instruction finishes, then IDLE.
  - step while busy: ignored, not queued.
  - run and step together in IDLE: run wins, step_mode=0.
- alu_op, alu_imm, rf_rd_addr_* are held stable from READ through WRITE.

## Timing
- Reset values: state=IDLE, pc=0, imem_addr=0, ir=0, rf_rd=0, rf_wr=0, all addresses 0, rf_wr_data=0, alu_op=0, alu_imm=0, alu_imm_sel=0, busy=0, halted=0, instr_count=0, step_mode=0.
- Reset mid-operation: rf_wr is forced 0 in the same cycle, and no write-back occurs.
- Instruction latency: 5 cycles, FETCH to WRITE inclusive.
- Free-run: one instruction per 5 cycles, with no IDLE gap.
- Step: step pulse in cycle N (IDLE) → FETCH at N+1 → rf_wr at N+5 → IDLE at N+6.
- Register bank read: registered, so data is valid in EXEC.
- alu_result: sampled at the end of EXEC.
- HALT: halted rises the cycle after DECODE.
- Outputs: all registered.

## Structure
- Shared package `isa_pkg` holds:
  - opcode localparams: OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_SLTI=0011, OP_OR=0100, OP_XOR=0101, OP_ANDI=0110, OP_ORI=0111, OP_XORI=1000, OP_ADDI=1001, OP_SUBI=1010, OP_HALT=1111.
  - the `is_imm(op)` and `is_defined(op)` functions.
  - the state encoding.
- One natural sub-module: `instr_decoder` (combinational; ir → alu_op, alu_imm, alu_imm_sel, addresses, is_halt, is_defined).
- FSM, PC and counters stay in `instr_sequencer`.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with run=1 → all outputs at reset values, no rf_wr. Release → FETCH with imem_addr=0 on the next cycle.
- Free-run: ROM[0]=16'h0312 (ADD r3,r1,r2), r1=5, r2=7 → rf_wr at cycle 5 with rf_wr_addr=3, rf_wr_data=12, pc=1. Next FETCH follows immediately.
- Single-step:
  - run=0, step pulse → exactly one write, then IDLE with busy=0 and instr_count=1.
  - Second step pulse issued during READ → ignored.
- Immediate: ROM[0]=16'h9452 (ADDI r4, imm=5, r2=7) → alu_imm_sel=1, alu_imm=5, rf_wr_addr=4, rf_wr_data=12.
- HALT and NOP:
  - ROM[0]=16'hB000, ROM[1]=16'hF000 → no rf_wr for the NOP, pc goes to 1, then halted=1 with pc=1.
  - run toggling has no effect once halted; rst_n clears halted.
- Wrap: PC_W=2 with four ADDs in free-run → pc sequence 1,2,3,0. Reset asserted during EXEC → no rf_wr and pc=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit instruction datapath: opcodes,
// opcode classification helpers and the sequencer state encoding.
package isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_SLTI = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_ANDI = 4'b0110;
    localparam logic [3:0] OP_ORI  = 4'b0111;
    localparam logic [3:0] OP_XORI = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    // Immediate-form opcodes take their second operand from ir[7:4].
    function automatic logic is_imm(input logic [3:0] op);
        case (op)
            OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_defined(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLTI, OP_OR, OP_XOR,
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into the
// ALU controls, register addresses and halt/defined classification.
module instr_decoder
    import isa_pkg::*;
#(
    parameter logic [3:0] HALT_OP = OP_HALT
) (
    input  logic [15:0] i_instr,
    output logic [3:0]  o_alu_op,
    output logic [3:0]  o_alu_imm,
    output logic        o_alu_imm_sel,
    output logic [3:0]  o_rd_addr_a,
    output logic [3:0]  o_rd_addr_b,
    output logic [3:0]  o_wr_addr,
    output logic        o_is_halt,
    output logic        o_is_defined
);

    assign o_alu_op      = i_instr[15:12];
    assign o_wr_addr     = i_instr[11:8];
    assign o_alu_imm     = i_instr[7:4];
    assign o_rd_addr_a   = i_instr[7:4];
    assign o_rd_addr_b   = i_instr[3:0];
    assign o_alu_imm_sel = is_imm(i_instr[15:12]);
    assign o_is_halt     = (i_instr[15:12] == HALT_OP);
    assign o_is_defined  = is_defined(i_instr[15:12]);

endmodule

// File: rtl/instr_sequencer.sv
// PC-driven fetch/decode/read/execute/write controller for the 16-bit ALU
// datapath, with free-run and single-step modes and a terminal HALT state.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int         PC_W    = 8,
    parameter logic [3:0] HALT_OP = OP_HALT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic            rf_rd,
    output logic [3:0]      rf_rd_addr_a,
    output logic [3:0]      rf_rd_addr_b,
    output logic            rf_wr,
    output logic [3:0]      rf_wr_addr,
    output logic [15:0]     rf_wr_data,
    output logic [3:0]      alu_op,
    output logic [3:0]      alu_imm,
    output logic            alu_imm_sel,
    input  logic [15:0]     alu_result,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     instr_count
);

    state_t          r_state;
    logic            r_step_mode;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_imem_addr;
    logic [15:0]     r_ir;
    logic            r_rf_rd;
    logic [3:0]      r_rd_addr_a;
    logic [3:0]      r_rd_addr_b;
    logic            r_rf_wr;
    logic [3:0]      r_wr_addr;
    logic [15:0]     r_wr_data;
    logic [3:0]      r_alu_op;
    logic [3:0]      r_alu_imm;
    logic            r_alu_imm_sel;
    logic            r_is_defined;
    logic            r_busy;
    logic            r_halted;
    logic [15:0]     r_instr_count;

    state_t          w_next_state;
    logic            w_step_mode_next;
    logic [PC_W-1:0] w_pc_next;
    logic [15:0]     w_ir_next;
    logic [3:0]      w_dec_alu_op;
    logic [3:0]      w_dec_alu_imm;
    logic            w_dec_imm_sel;
    logic [3:0]      w_dec_rd_addr_a;
    logic [3:0]      w_dec_rd_addr_b;
    logic [3:0]      w_dec_wr_addr;
    logic            w_dec_is_halt;
    logic            w_dec_is_defined;

    // The ROM word is only valid during DECODE; otherwise ir holds the
    // current instruction so every decoded field stays stable until the
    // next fetch completes.
    assign w_ir_next = (r_state == ST_DECODE) ? imem_rdata : r_ir;

    instr_decoder #(
        .HALT_OP (HALT_OP)
    ) u_decoder (
        .i_instr       (w_ir_next),
        .o_alu_op      (w_dec_alu_op),
        .o_alu_imm     (w_dec_alu_imm),
        .o_alu_imm_sel (w_dec_imm_sel),
        .o_rd_addr_a   (w_dec_rd_addr_a),
        .o_rd_addr_b   (w_dec_rd_addr_b),
        .o_wr_addr     (w_dec_wr_addr),
        .o_is_halt     (w_dec_is_halt),
        .o_is_defined  (w_dec_is_defined)
    );

    assign w_pc_next = (r_state == ST_WRITE) ? r_pc + PC_W'(1) : r_pc;

    always_comb begin
        w_next_state     = r_state;
        w_step_mode_next = r_step_mode;
        unique case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state     = ST_FETCH;
                    w_step_mode_next = 1'b0;
                end else if (step) begin
                    w_next_state     = ST_FETCH;
                    w_step_mode_next = 1'b1;
                end
            end
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = w_dec_is_halt ? ST_HALTED : ST_READ;
            ST_READ:   w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = ST_WRITE;
            ST_WRITE: begin
                w_next_state     = (run && !r_step_mode) ? ST_FETCH : ST_IDLE;
                w_step_mode_next = 1'b0;
            end
            ST_HALTED: w_next_state = ST_HALTED;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Strobes and status are computed from the next state so that every
    // output is a plain register aligned with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_step_mode   <= 1'b0;
            r_pc          <= '0;
            r_imem_addr   <= '0;
            r_ir          <= '0;
            r_rf_rd       <= 1'b0;
            r_rd_addr_a   <= '0;
            r_rd_addr_b   <= '0;
            r_rf_wr       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_alu_op      <= '0;
            r_alu_imm     <= '0;
            r_alu_imm_sel <= 1'b0;
            r_is_defined  <= 1'b0;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_next_state;
            r_step_mode   <= w_step_mode_next;
            r_pc          <= w_pc_next;
            r_imem_addr   <= w_pc_next;
            r_ir          <= w_ir_next;
            r_rd_addr_a   <= w_dec_rd_addr_a;
            r_rd_addr_b   <= w_dec_rd_addr_b;
            r_wr_addr     <= w_dec_wr_addr;
            r_alu_op      <= w_dec_alu_op;
            r_alu_imm     <= w_dec_alu_imm;
            r_alu_imm_sel <= w_dec_imm_sel;
            r_is_defined  <= w_dec_is_defined;
            r_rf_rd       <= (w_next_state == ST_READ);
            r_rf_wr       <= (w_next_state == ST_WRITE) && r_is_defined;
            r_busy        <= (w_next_state != ST_IDLE) && (w_next_state != ST_HALTED);
            r_halted      <= (w_next_state == ST_HALTED);
            if (r_state == ST_EXEC) begin
                r_wr_data <= alu_result;
            end
            if ((r_state == ST_WRITE) && (r_instr_count != 16'hFFFF)) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    assign imem_addr    = r_imem_addr;
    assign pc           = r_pc;
    assign rf_rd        = r_rf_rd;
    assign rf_rd_addr_a = r_rd_addr_a;
    assign rf_rd_addr_b = r_rd_addr_b;
    // Reset asserted during WRITE must cancel the write-back immediately,
    // before the synchronous reset has a chance to clear the strobe.
    assign rf_wr        = r_rf_wr & rst_n;
    assign rf_wr_addr   = r_wr_addr;
    assign rf_wr_data   = r_wr_data;
    assign alu_op       = r_alu_op;
    assign alu_imm      = r_alu_imm;
    assign alu_imm_sel  = r_alu_imm_sel;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a ROM, register bank and ALU
// environment around the DUT, a table of single-step vectors and directed sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        run;
    logic        step;
    logic [1:0]  imemAddr;
    logic [15:0] imemRdata;
    logic        rfRd;
    logic [3:0]  rfRdAddrA;
    logic [3:0]  rfRdAddrB;
    logic        rfWr;
    logic [3:0]  rfWrAddr;
    logic [15:0] rfWrData;
    logic [3:0]  aluOp;
    logic [3:0]  aluImm;
    logic        aluImmSel;
    logic [15:0] aluResult;
    logic [1:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instrCount;

    logic [15:0] rom [4];
    logic [15:0] regs [16];
    logic [15:0] rdA;
    logic [15:0] rdB;
    logic        regInit;

    int total = 0;
    int bad   = 0;
    int wrSeen = 0;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  expOp;
        logic [3:0]  expImm;
        logic        expImmSel;
        logic        expWr;
        logic [3:0]  expAddr;
        logic [15:0] expData;
    } vecT;

    vecT vecs [13];

    instr_sequencer #(
        .PC_W    (2),
        .HALT_OP (4'b1111)
    ) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .run          (run),
        .step         (step),
        .imem_addr    (imemAddr),
        .imem_rdata   (imemRdata),
        .rf_rd        (rfRd),
        .rf_rd_addr_a (rfRdAddrA),
        .rf_rd_addr_b (rfRdAddrB),
        .rf_wr        (rfWr),
        .rf_wr_addr   (rfWrAddr),
        .rf_wr_data   (rfWrData),
        .alu_op       (aluOp),
        .alu_imm      (aluImm),
        .alu_imm_sel  (aluImmSel),
        .alu_result   (aluResult),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .instr_count  (instrCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imemRdata <= rom[imemAddr];

    // Registered register bank: reads land in EXEC, writes at end of WRITE.
    always @(posedge clk) begin
        if (regInit) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            regs[1] <= 16'd5;
            regs[2] <= 16'd7;
            rdA <= 16'h0000;
            rdB <= 16'h0000;
        end else begin
            if (rfRd) begin
                rdA <= regs[rfRdAddrA];
                rdB <= regs[rfRdAddrB];
            end
            if (rfWr) regs[rfWrAddr] <= rfWrData;
        end
    end

    always_comb begin
        logic [15:0] imm16;
        imm16 = {12'h000, aluImm};
        case (aluOp)
            4'h0:    aluResult = rdA + rdB;
            4'h1:    aluResult = rdA - rdB;
            4'h2:    aluResult = rdA & rdB;
            4'h3:    aluResult = (rdB < imm16) ? 16'h0001 : 16'h0000;
            4'h4:    aluResult = rdA | rdB;
            4'h5:    aluResult = rdA ^ rdB;
            4'h6:    aluResult = rdB & imm16;
            4'h7:    aluResult = rdB | imm16;
            4'h8:    aluResult = rdB ^ imm16;
            4'h9:    aluResult = rdB + imm16;
            4'hA:    aluResult = rdB - imm16;
            default: aluResult = 16'hDEAD;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rfWr) wrSeen++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        regInit = 1'b1;
        run = 1'b0;
        step = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
        regInit = 1'b0;
        wrSeen = 0;
    endtask

    // One single-step instruction from ROM[0], checked phase by phase.
    task automatic applyStimulus(input vecT v, input int idx);
        doReset();
        rom[0] = v.instr;
        rom[1] = 16'hF000;
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput($sformatf("vec%0d.fetchBusy", idx), busy, 1);
        tick();
        tick();
        checkOutput($sformatf("vec%0d.readStrobe", idx), rfRd, 1);
        checkOutput($sformatf("vec%0d.readAddrB", idx), rfRdAddrB, v.instr[3:0]);
        tick();
        checkOutput($sformatf("vec%0d.aluOp", idx), aluOp, v.expOp);
        checkOutput($sformatf("vec%0d.aluImm", idx), aluImm, v.expImm);
        checkOutput($sformatf("vec%0d.aluImmSel", idx), aluImmSel, v.expImmSel);
        tick();
        checkOutput($sformatf("vec%0d.wrStrobe", idx), rfWr, v.expWr);
        if (v.expWr) begin
            checkOutput($sformatf("vec%0d.wrAddr", idx), rfWrAddr, v.expAddr);
            checkOutput($sformatf("vec%0d.wrData", idx), rfWrData, v.expData);
        end
        tick();
        tick();
        checkOutput($sformatf("vec%0d.idleBusy", idx), busy, 0);
        checkOutput($sformatf("vec%0d.pc", idx), pc, 1);
        checkOutput($sformatf("vec%0d.count", idx), instrCount, 1);
        checkOutput($sformatf("vec%0d.wrPulses", idx), wrSeen, v.expWr);
    endtask

    initial begin
        logic [1:0] expPc [4];
        int wrBefore;

        vecs[0]  = '{16'h0312, 4'h0, 4'h1, 1'b0, 1'b1, 4'h3, 16'h000C};
        vecs[1]  = '{16'h1512, 4'h1, 4'h1, 1'b0, 1'b1, 4'h5, 16'hFFFE};
        vecs[2]  = '{16'h2A12, 4'h2, 4'h1, 1'b0, 1'b1, 4'hA, 16'h0005};
        vecs[3]  = '{16'h4612, 4'h4, 4'h1, 1'b0, 1'b1, 4'h6, 16'h0007};
        vecs[4]  = '{16'h5712, 4'h5, 4'h1, 1'b0, 1'b1, 4'h7, 16'h0002};
        vecs[5]  = '{16'h9452, 4'h9, 4'h5, 1'b1, 1'b1, 4'h4, 16'h000C};
        vecs[6]  = '{16'h3192, 4'h3, 4'h9, 1'b1, 1'b1, 4'h1, 16'h0001};
        vecs[7]  = '{16'h6232, 4'h6, 4'h3, 1'b1, 1'b1, 4'h2, 16'h0003};
        vecs[8]  = '{16'h7882, 4'h7, 4'h8, 1'b1, 1'b1, 4'h8, 16'h000F};
        vecs[9]  = '{16'h8F52, 4'h8, 4'h5, 1'b1, 1'b1, 4'hF, 16'h0002};
        vecs[10] = '{16'hA3C2, 4'hA, 4'hC, 1'b1, 1'b1, 4'h3, 16'hFFFB};
        vecs[11] = '{16'hB312, 4'hB, 4'h1, 1'b0, 1'b0, 4'h0, 16'h0000};
        vecs[12] = '{16'hE312, 4'hE, 4'h1, 1'b0, 1'b0, 4'h0, 16'h0000};

        // Reset held with run high, then free-run straight out of reset.
        rom[0] = 16'h0312;
        rom[1] = 16'h0431;
        rom[2] = 16'h0312;
        rom[3] = 16'hF000;
        rstN = 1'b0;
        run = 1'b1;
        step = 1'b0;
        regInit = 1'b1;
        repeat (3) tick();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstHalted", halted, 0);
        checkOutput("rstWr", rfWr, 0);
        checkOutput("rstRd", rfRd, 0);
        checkOutput("rstPc", pc, 0);
        checkOutput("rstImemAddr", imemAddr, 0);
        checkOutput("rstCount", instrCount, 0);
        checkOutput("rstWrData", rfWrData, 0);
        checkOutput("rstWrAddr", rfWrAddr, 0);
        checkOutput("rstAluOp", aluOp, 0);
        checkOutput("rstAluImm", aluImm, 0);
        checkOutput("rstImmSel", aluImmSel, 0);
        checkOutput("rstRdAddrA", rfRdAddrA, 0);
        checkOutput("rstRdAddrB", rfRdAddrB, 0);
        checkOutput("rstNoWrite", wrSeen, 0);
        rstN = 1'b1;
        regInit = 1'b0;
        tick();
        checkOutput("runFetchBusy", busy, 1);
        checkOutput("runFetchAddr", imemAddr, 0);
        repeat (4) tick();
        checkOutput("run0Wr", rfWr, 1);
        checkOutput("run0WrAddr", rfWrAddr, 3);
        checkOutput("run0WrData", rfWrData, 16'd12);
        checkOutput("run0PcHeld", pc, 0);
        tick();
        checkOutput("run1FetchBusy", busy, 1);
        checkOutput("run1Pc", pc, 1);
        checkOutput("run1ImemAddr", imemAddr, 1);
        checkOutput("run1WrLow", rfWr, 0);
        repeat (4) tick();
        checkOutput("run1Wr", rfWr, 1);
        checkOutput("run1WrAddr", rfWrAddr, 4);
        checkOutput("run1WrData", rfWrData, 16'd17);
        tick();
        tick();
        run = 1'b0;
        repeat (3) tick();
        checkOutput("runDropWr", rfWr, 1);
        checkOutput("runDropWrData", rfWrData, 16'd12);
        tick();
        checkOutput("runDropIdle", busy, 0);
        checkOutput("runDropPc", pc, 3);
        checkOutput("runDropCount", instrCount, 3);
        repeat (3) tick();
        checkOutput("runDropStays", busy, 0);

        // Table of single-step instructions covering every opcode class.
        for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

        // A second step pulse during READ must not be queued.
        doReset();
        rom[0] = 16'h0312;
        rom[1] = 16'h0431;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        checkOutput("stepReadRd", rfRd, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checkOutput("stepWr", rfWr, 1);
        tick();
        checkOutput("stepIdle", busy, 0);
        repeat (6) tick();
        checkOutput("stepWrPulses", wrSeen, 1);
        checkOutput("stepBusy", busy, 0);
        checkOutput("stepCount", instrCount, 1);
        checkOutput("stepPc", pc, 1);

        // run and step together: run wins, so no IDLE after the first write.
        doReset();
        run = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        checkOutput("bothNoIdle", busy, 1);
        checkOutput("bothPc", pc, 1);
        run = 1'b0;
        repeat (6) tick();
        checkOutput("bothStopBusy", busy, 0);
        checkOutput("bothCount", instrCount, 2);
        checkOutput("bothWrPulses", wrSeen, 2);

        // NOP then HALT; halted is sticky until reset.
        doReset();
        rom[0] = 16'hB000;
        rom[1] = 16'hF000;
        run = 1'b1;
        repeat (5) tick();
        checkOutput("nopNoWr", rfWr, 0);
        tick();
        checkOutput("nopPc", pc, 1);
        tick();
        checkOutput("haltNotYet", halted, 0);
        tick();
        checkOutput("haltRise", halted, 1);
        checkOutput("haltBusy", busy, 0);
        checkOutput("haltPc", pc, 1);
        run = 1'b0;
        repeat (3) tick();
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checkOutput("haltSticky", halted, 1);
        checkOutput("haltStickyPc", pc, 1);
        checkOutput("haltStickyBusy", busy, 0);
        checkOutput("haltCount", instrCount, 1);
        checkOutput("haltNoWr", wrSeen, 0);
        rstN = 1'b0;
        tick();
        checkOutput("haltCleared", halted, 0);
        rstN = 1'b1;

        // PC wrap with a 2-bit PC, then reset landing in EXEC.
        doReset();
        for (int i = 0; i < 4; i++) rom[i] = 16'h0312;
        expPc[0] = 2'd1;
        expPc[1] = 2'd2;
        expPc[2] = 2'd3;
        expPc[3] = 2'd0;
        run = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k >= 6 && ((k - 6) % 5) == 0) begin
                checkOutput($sformatf("wrapPc%0d", (k - 6) / 5), pc, expPc[(k - 6) / 5]);
            end
        end
        checkOutput("wrapExecBusy", busy, 1);
        checkOutput("wrapWrCount", wrSeen, 4);
        wrBefore = wrSeen;
        rstN = 1'b0;
        tick();
        checkOutput("execRstWr", rfWr, 0);
        checkOutput("execRstPc", pc, 0);
        checkOutput("execRstBusy", busy, 0);
        tick();
        checkOutput("execRstNoWr", wrSeen, wrBefore);
        rstN = 1'b1;
        run = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
